// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the core-side memory path.
package cpu_types_pkg;
  localparam int DEF_ADDR_LSB = 2;
  localparam int LINK_W       = 32 - DEF_ADDR_LSB;

  typedef enum logic [2:0] {REQ_I, REQ_DR, REQ_DW, REQ_LL, REQ_SC} memreq_t;
  typedef enum logic {IDLE, ACCESS} arb_state_t;

  function automatic logic is_write(input memreq_t t);
    return (t == REQ_DW) || (t == REQ_SC);
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder: first set request at or after ptr wins.
module rr_picker #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  int unsigned k;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among CPUS cores, with LL/SC link registers.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int CPUS     = 2,
  parameter  int ADDR_LSB = DEF_ADDR_LSB,
  localparam int IW       = (CPUS > 1) ? $clog2(CPUS) : 1,
  localparam int LW       = 32 - ADDR_LSB
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS-1:0]      datomic,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [31:0]          iload,
  output logic [31:0]          dload,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_store,
  input  logic [31:0]          ram_load,
  input  logic                 ram_ready
);
  arb_state_t               state_q, state_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]            owner_q, owner_d;
  memreq_t                  type_q, type_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              store_q, store_d;
  logic [CPUS-1:0]          link_valid_q, link_valid_d;
  logic [CPUS-1:0][LW-1:0]  link_addr_q, link_addr_d;

  logic [CPUS-1:0] dreq, anyreq, win_gnt;
  logic [IW-1:0]   win;
  logic            win_vld, win_dwen, win_dren, win_atom;
  logic [31:0]     win_daddr, win_iaddr, win_store, win_addr;
  memreq_t         win_type;
  logic            sc_fail, own_req, acc, abort, done, idle_done, grant;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
    return (int'(p) == CPUS - 1) ? '0 : p + IW'(1);
  endfunction

  assign dreq   = dREN | dWEN;
  assign anyreq = iREN | dreq;

  rr_picker #(.N(CPUS)) u_pick (
    .req (anyreq),
    .ptr (rr_ptr_q),
    .gnt (win_gnt),
    .idx (win),
    .vld (win_vld)
  );

  // Winner decode: data beats instruction, a write beats a read if both are raised.
  always_comb begin
    win_dwen  = |(win_gnt & dWEN);
    win_dren  = |(win_gnt & dREN);
    win_atom  = |(win_gnt & datomic);
    win_daddr = daddr[32*int'(win) +: 32];
    win_iaddr = iaddr[32*int'(win) +: 32];
    win_store = dstore[32*int'(win) +: 32];
    win_type  = REQ_I;
    if (win_dwen)      win_type = win_atom ? REQ_SC : REQ_DW;
    else if (win_dren) win_type = win_atom ? REQ_LL : REQ_DR;
    win_addr  = (win_dwen || win_dren) ? win_daddr : win_iaddr;
    sc_fail   = win_vld && (win_type == REQ_SC) &&
                !(link_valid_q[win] && (link_addr_q[win] == win_daddr[31:ADDR_LSB]));
    grant     = (state_q == IDLE) && win_vld && !sc_fail;
    idle_done = (state_q == IDLE) && sc_fail;
  end

  always_comb begin
    case (type_q)
      REQ_I:          own_req = iREN[owner_q];
      REQ_DR, REQ_LL: own_req = dREN[owner_q];
      default:        own_req = dWEN[owner_q];
    endcase
    acc   = (state_q == ACCESS);
    abort = acc && !own_req;
    done  = acc && own_req && ram_ready;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)         state_d = ACCESS;
      ACCESS:  if (abort || done) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // An aborted access leaves rr_ptr and links untouched.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    type_d       = type_q;
    addr_d       = addr_q;
    store_d      = store_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (grant) begin
      owner_d = win;
      type_d  = win_type;
      addr_d  = win_addr;
      store_d = win_store;
    end
    if (idle_done) rr_ptr_d = next_ptr(win);
    if (done) begin
      rr_ptr_d = next_ptr(owner_q);
      for (int k = 0; k < CPUS; k++) begin
        if (type_q == REQ_LL && int'(owner_q) == k) begin
          link_valid_d[k] = 1'b1;
          link_addr_d[k]  = addr_q[31:ADDR_LSB];
        end
        if (is_write(type_q) && link_addr_q[k] == addr_q[31:ADDR_LSB])
          link_valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      type_q       <= REQ_I;
      addr_q       <= '0;
      store_q      <= '0;
      link_valid_q <= '0;
      link_addr_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  // Outputs decode from state_q so the RAM enables fall with reset, not the next edge.
  always_comb begin
    ram_ren   = acc && (type_q == REQ_I || type_q == REQ_DR || type_q == REQ_LL);
    ram_wen   = acc && is_write(type_q);
    ram_addr  = acc ? addr_q : '0;
    ram_store = ram_wen ? store_q : '0;
    iload     = (done && type_q == REQ_I) ? ram_load : '0;
    dload     = '0;
    if (done && (type_q == REQ_DR || type_q == REQ_LL)) dload = ram_load;
    else if (done && type_q == REQ_SC)                  dload = 32'h1;
    for (int k = 0; k < CPUS; k++) begin
      iwait[k] = iREN[k] & ~(done && int'(owner_q) == k && type_q == REQ_I);
      dwait[k] = dreq[k] & ~((done && int'(owner_q) == k && type_q != REQ_I) ||
                             (idle_done && int'(win) == k));
    end
  end
endmodule
